// File: rtl/issue_ctrl.sv
// Dual-issue controller for the ID->EX boundary: issues an instruction pair together,
// or splits it across cycles. Optional perf counters are enabled by `define ISSUE_PERF_CNT_EN.
module issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_allowin,
    input  logic        line1_valid_i,
    input  logic        line2_valid_i,
    input  logic        line1_regs_read_ready_i,
    input  logic        line2_regs_read_ready_i,
    input  logic        line2_raw_line1_i,
    input  logic        line2_solo_i,
    output logic        issue_line1_o,
    output logic        issue_line2_o,
    output logic [1:0]  id_pop_o,
    output logic        split_o,
    output logic        deadlock_o,
    output logic [31:0] split_cnt_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [0:0] S_PAIR  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] wd_q;
    logic       pending, wd_count, go_split, any_issue;

    // Strobes are forced low during reset so nothing leaks into EX.
    always_comb begin
        issue_line1_o = 1'b0;
        issue_line2_o = 1'b0;
        id_pop_o      = 2'd0;
        if (!rst) begin
            if (state_q == S_PAIR) begin
                issue_line1_o = line1_valid_i & line1_regs_read_ready_i & ex_allowin & ~flush;
                issue_line2_o = issue_line1_o & line2_valid_i & line2_regs_read_ready_i
                              & ~line2_raw_line1_i & ~line2_solo_i;
                if (issue_line2_o)
                    id_pop_o = 2'd2;
                else if (issue_line1_o && !line2_valid_i)
                    id_pop_o = 2'd1;
            end else begin
                issue_line2_o = line2_valid_i & line2_regs_read_ready_i & ex_allowin & ~flush;
                if (issue_line2_o)
                    id_pop_o = 2'd2;
                else if (!line2_valid_i && !flush)
                    id_pop_o = 2'd1;
            end
        end
    end

    assign any_issue = issue_line1_o | issue_line2_o;
    assign go_split  = (state_q == S_PAIR) & issue_line1_o & line2_valid_i & ~issue_line2_o;
    assign pending   = (state_q == S_SPLIT) ? line2_valid_i : line1_valid_i;
    assign wd_count  = pending & ex_allowin & ~any_issue & ~flush;

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = S_PAIR;
        else if (go_split)
            state_d = S_SPLIT;
        else if (state_q == S_SPLIT && (issue_line2_o || !line2_valid_i))
            state_d = S_PAIR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PAIR;
            wd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            if (flush || any_issue)
                wd_q <= 8'd0;
            else if (wd_count && wd_q != 8'hFF)
                wd_q <= wd_q + 8'd1;
        end
    end

    assign split_o    = (state_q == S_SPLIT);
    assign deadlock_o = (wd_q == 8'hFF);

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] split_cnt_q, stall_cnt_q;

    // Free-running and wrapping; flush deliberately does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (go_split)
                split_cnt_q <= split_cnt_q + 32'd1;
            if (wd_count)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign split_cnt_o = split_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign split_cnt_o = 32'd0;
    assign stall_cnt_o = 32'd0;
`endif

endmodule
